// File: rtl/cgra_seq_ctrl.sv
// ---------------------------------------------------------------------------
// cgra_seq_ctrl
//   Load+run sequencer for a small CGRA.
//   A start clears the PEs for one cycle. The controller then streams
//   NUM_PE*ctx_num configuration words into the PEs in PE-major order. It
//   then pulses run for ctx_num cycles, waits out the two-stage PE pipeline,
//   and reports done.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   start, abort    job request / job cancel
//   ctx_num         contexts per PE (1..DEPTH), captured on an accepted start
//   cfg_valid/ready/data   configuration word stream (valid/ready handshake)
//   pe_inst         instruction broadcast; non-zero only during an init strobe
//   pe_init         one-hot per-PE init strobe
//   pe_run, pe_rst  broadcast run / reset strobes
//   busy, done, err job in progress / job complete pulse / illegal start pulse
//   stall_cnt       (only with SEQ_CTRL_PERF_CNT_EN) LOAD cycles with no valid word
//
// Optional feature macro: SEQ_CTRL_PERF_CNT_EN
//
// State   | meaning
// --------+-------------------------------------------------
// S_IDLE  | waiting for a legal start
// S_CLR   | one-cycle PE reset before loading
// S_LOAD  | accepting configuration words, PE-major order
// S_RUN   | pe_run asserted for ctx_num cycles
// S_DRAIN | two cycles for PE instruction/result registers
// S_DONE  | one-cycle done pulse
// ---------------------------------------------------------------------------
module cgra_seq_ctrl #(
    parameter int PE_INST_W = 28,
    parameter int NUM_PE    = 4,
    parameter int DEPTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [$clog2(DEPTH):0]   ctx_num,
    input  logic                     cfg_valid,
    input  logic [PE_INST_W-1:0]     cfg_data,
    output logic                     cfg_ready,
    output logic [PE_INST_W-1:0]     pe_inst,
    output logic [NUM_PE-1:0]        pe_init,
    output logic                     pe_run,
    output logic                     pe_rst,
    output logic                     busy,
    output logic                     done,
    output logic                     err
`ifdef SEQ_CTRL_PERF_CNT_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pe_idx_q, pe_idx_d;
    logic [CW-1:0]   ctx_idx_q, ctx_idx_d;
    logic [CW-1:0]   ctx_num_q, ctx_num_d;
    logic [CW-1:0]   tmr_q, tmr_d;
    // Delivers the post-abort PE reset in the cycle after abort, when the FSM is already back in IDLE.
    logic            abort_rst_q, abort_rst_d;

    logic            start_ok;
    logic            xfer;

    assign start_ok = start && (ctx_num != '0) && (ctx_num <= CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pe_idx_q    <= '0;
            ctx_idx_q   <= '0;
            ctx_num_q   <= '0;
            tmr_q       <= '0;
            abort_rst_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pe_idx_q    <= pe_idx_d;
            ctx_idx_q   <= ctx_idx_d;
            ctx_num_q   <= ctx_num_d;
            tmr_q       <= tmr_d;
            abort_rst_q <= abort_rst_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pe_idx_d    = pe_idx_q;
        ctx_idx_d   = ctx_idx_q;
        ctx_num_d   = ctx_num_q;
        tmr_d       = tmr_q;
        abort_rst_d = 1'b0;

        cfg_ready   = 1'b0;
        pe_inst     = '0;
        pe_init     = '0;
        pe_run      = 1'b0;
        pe_rst      = abort_rst_q;
        busy        = (state_q != S_IDLE);
        done        = 1'b0;
        err         = 1'b0;
        xfer        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    ctx_num_d = ctx_num;
                    state_d   = S_CLR;
                end else if (start) begin
                    err = 1'b1;
                end
            end
            S_CLR: begin
                pe_rst    = 1'b1;
                pe_idx_d  = '0;
                ctx_idx_d = '0;
                state_d   = S_LOAD;
            end
            S_LOAD: begin
                // Dropping ready under abort keeps the source from treating
                // the abandoned word as consumed.
                cfg_ready = !abort;
                xfer      = cfg_valid && cfg_ready;
                if (xfer) begin
                    pe_inst = cfg_data;
                    for (int i = 0; i < NUM_PE; i++) begin
                        pe_init[i] = (pe_idx_q == PW'(i));
                    end
                    if (ctx_idx_q == ctx_num_q - CW'(1)) begin
                        ctx_idx_d = '0;
                        if (pe_idx_q == PW'(NUM_PE - 1)) begin
                            state_d = S_RUN;
                            tmr_d   = ctx_num_q - CW'(1);
                        end else begin
                            pe_idx_d = pe_idx_q + PW'(1);
                        end
                    end else begin
                        ctx_idx_d = ctx_idx_q + CW'(1);
                    end
                end
            end
            S_RUN: begin
                pe_run = !abort;
                if (tmr_q == '0) begin
                    state_d = S_DRAIN;
                    tmr_d   = CW'(1);
                end else begin
                    tmr_d = tmr_q - CW'(1);
                end
            end
            S_DRAIN: begin
                if (tmr_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    tmr_d = tmr_q - CW'(1);
                end
            end
            S_DONE: begin
                done    = !abort;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            abort_rst_d = 1'b1;
        end
    end

`ifdef SEQ_CTRL_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == S_IDLE) && start_ok) begin
            stall_cnt_d = '0;
        end else if ((state_q == S_LOAD) && !cfg_valid && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cgra_seq_ctrl.sv
module tb_cgra_seq_ctrl;

    localparam int PE_INST_W = 28;
    localparam int NUM_PE    = 4;
    localparam int DEPTH     = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic                  abort = 1'b0;
    logic [4:0]            ctx_num = '0;
    logic                  cfg_valid = 1'b0;
    logic [PE_INST_W-1:0]  cfg_data = '0;
    logic                  cfg_ready;
    logic [PE_INST_W-1:0]  pe_inst;
    logic [NUM_PE-1:0]     pe_init;
    logic                  pe_run;
    logic                  pe_rst;
    logic                  busy;
    logic                  done;
    logic                  err;
`ifdef SEQ_CTRL_PERF_CNT_EN
    logic [15:0]           stall_cnt;
`endif

    cgra_seq_ctrl #(
        .PE_INST_W (PE_INST_W),
        .NUM_PE    (NUM_PE),
        .DEPTH     (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .ctx_num   (ctx_num),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .pe_inst   (pe_inst),
        .pe_init   (pe_init),
        .pe_run    (pe_run),
        .pe_rst    (pe_rst),
        .busy      (busy),
        .done      (done),
        .err       (err)
`ifdef SEQ_CTRL_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0]          cyc;
        logic [NUM_PE-1:0]    init;
        logic                 run;
        logic                 prst;
        logic                 dn;
        logic                 er;
        logic [PE_INST_W-1:0] inst;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    bit  mon_en   = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int c, input logic [NUM_PE-1:0] init, input logic run,
                           input logic prst, input logic dn, input logic er,
                           input logic [PE_INST_W-1:0] inst);
        ev_t e;
        e.cyc  = 32'(c);
        e.init = init;
        e.run  = run;
        e.prst = prst;
        e.dn   = dn;
        e.er   = er;
        e.inst = inst;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every cycle with a strobe pops one expected event.
    always @(negedge clk) begin
        if (mon_en) begin
            ev_t a;
            ev_t e;
            checks++;
            if (($countones({|pe_init, pe_run, pe_rst}) > 1) || ((pe_init == '0) && (pe_inst != '0))) begin
                failures++;
                $display("FAIL strobe_excl: init=%b run=%b rst=%b inst=%h cycle %0d",
                         pe_init, pe_run, pe_rst, pe_inst, cyc);
            end
            if ((pe_init != '0) || pe_run || pe_rst || done || err) begin
                a.cyc  = 32'(cyc);
                a.init = pe_init;
                a.run  = pe_run;
                a.prst = pe_rst;
                a.dn   = done;
                a.er   = err;
                a.inst = pe_inst;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_ev: got cyc=%0d init=%b run=%b rst=%b done=%b err=%b inst=%h, expected none",
                             a.cyc, a.init, a.run, a.prst, a.dn, a.er, a.inst);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        failures++;
                        $display("FAIL event: got cyc=%0d init=%b run=%b rst=%b done=%b err=%b inst=%h, expected cyc=%0d init=%b run=%b rst=%b done=%b err=%b inst=%h",
                                 a.cyc, a.init, a.run, a.prst, a.dn, a.er, a.inst,
                                 e.cyc, e.init, e.run, e.prst, e.dn, e.er, e.inst);
                    end
                end
            end
        end
    end

    // One full job from IDLE. vpat bit k gives cfg_valid on the k-th LOAD cycle.
    // abort_run >= 0 aborts on that RUN cycle; start_in_run re-pulses start on RUN cycle 0.
    task automatic do_job(input int ctxn, input logic [31:0] vpat, input int abort_run,
                          input bit start_in_run);
        int pe;
        int cx;
        int n;
        int k;
        int stalls;
        pe = 0; cx = 0; n = 0; k = 0; stalls = 0;
        ctx_num = 5'(ctxn);
        start   = 1'b1;
        tick();
        start = 1'b0;
        push_ev(cyc, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        check("busy_clr", 64'(busy), 64'd1);
        tick();
        while (n < NUM_PE * ctxn) begin
            cfg_valid = vpat[k % 32];
            cfg_data  = {4'hA, 8'(pe), 8'(cx), 8'(k)};
            if (cfg_valid) begin
                push_ev(cyc, NUM_PE'(1 << pe), 1'b0, 1'b0, 1'b0, 1'b0, cfg_data);
                n++;
                if (cx == ctxn - 1) begin
                    cx = 0;
                    pe++;
                end else begin
                    cx++;
                end
            end else begin
                stalls++;
            end
            k++;
            tick();
        end
        cfg_valid = 1'b0;
        cfg_data  = '0;
        for (int r = 0; r < ctxn; r++) begin
            if (r == abort_run) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                push_ev(cyc, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
                check("busy_after_abort", 64'(busy), 64'd0);
                repeat (6) tick();
                return;
            end
            push_ev(cyc, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
            if (start_in_run && r == 0) begin
                start   = 1'b1;
                ctx_num = 5'd5;
            end
            tick();
            start = 1'b0;
        end
        tick();
        tick();
        push_ev(cyc, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        tick();
        check("busy_after_done", 64'(busy), 64'd0);
`ifdef SEQ_CTRL_PERF_CNT_EN
        check("stall_cnt", 64'(stall_cnt), 64'(stalls));
`endif
        tick();
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        check("rst_state", 64'({busy, cfg_ready, pe_init, pe_run, pe_rst, done, err}), 64'd0);
        mon_en = 1'b1;
        tick();

        // nominal 4 PEs x 3 contexts; done lands 18 cycles after CLR
        do_job(3, 32'hFFFF_FFFF, -1, 1'b0);

        // illegal ctx_num values
        ctx_num = 5'd0;
        start   = 1'b1;
        push_ev(cyc, '0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        tick();
        start = 1'b0;
        check("busy_err0", 64'(busy), 64'd0);
        tick();
        ctx_num = 5'd17;
        start   = 1'b1;
        push_ev(cyc, '0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        tick();
        start = 1'b0;
        check("busy_err17", 64'(busy), 64'd0);
        tick();

        // toggled cfg_valid, then a smallest job with a 1,1,0,0 pattern
        do_job(2, 32'h5555_5555, -1, 1'b0);
        do_job(1, 32'h3333_3333, -1, 1'b0);

        // abort on second RUN cycle
        do_job(3, 32'hFFFF_FFFF, 1, 1'b0);

        // start during RUN is ignored, even with a new ctx_num on the bus
        do_job(2, 32'hFFFF_FFFF, -1, 1'b1);

        // abort in IDLE does nothing
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        check("busy_idle_abort", 64'(busy), 64'd0);

        // abort in LOAD on a valid word: no init strobe, one pe_rst
        ctx_num = 5'd1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        push_ev(cyc, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        tick();
        check("cfg_ready_load", 64'(cfg_ready), 64'd1);
        cfg_valid = 1'b1;
        cfg_data  = 28'h1234567;
        abort     = 1'b1;
        tick();
        cfg_valid = 1'b0;
        cfg_data  = '0;
        abort     = 1'b0;
        push_ev(cyc, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        check("busy_load_abort", 64'(busy), 64'd0);
        tick();

        // rst mid-LOAD, then a fresh job restarts at PE0 ctx0
        ctx_num = 5'd2;
        start   = 1'b1;
        tick();
        start = 1'b0;
        push_ev(cyc, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        tick();
        for (int j = 0; j < 2; j++) begin
            cfg_valid = 1'b1;
            cfg_data  = 28'hBEEF000 + 28'(j);
            push_ev(cyc, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, cfg_data);
            tick();
        end
        cfg_valid = 1'b0;
        cfg_data  = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_midload", 64'({busy, cfg_ready, pe_init, pe_run, pe_rst, done, err}), 64'd0);
`ifdef SEQ_CTRL_PERF_CNT_EN
        check("stall_rst", 64'(stall_cnt), 64'd0);
`endif
        tick();
        do_job(2, 32'hFFFF_FFFF, -1, 1'b0);

        // largest legal job
        do_job(16, 32'hFFFF_FFFF, -1, 1'b0);

        repeat (5) tick();
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
